// File: rtl/exc_pkg.sv
// Shared constants, state encoding and event-priority helper for the CP0 exception sequencer.
package exc_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [XLEN-1:0] HANDLER_ADDR = 32'h0000_0100;
  localparam int unsigned QUIET_CYCLES = 2;
  localparam int unsigned QCNT_W       = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [1:0] INT    = 2'd0;
  localparam logic [1:0] SYS    = 2'd1;
  localparam logic [1:0] UNIMPL = 2'd2;
  localparam logic [1:0] OV     = 2'd3;

  localparam logic [3:0] FLUSH_ALL = 4'b1111;
  localparam logic [3:0] FLUSH_RET = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTER,
    ST_RET,
    ST_QUIET
  } exc_state_e;

  typedef struct packed {
    logic            valid;
    logic            is_ret;
    logic [1:0]      code;
    logic [XLEN-1:0] src_pc;
  } exc_sel_t;

  // Oldest instruction wins: OV(M) > ERET(M) > UNIMPL(E) > SYS(D) > INT.
  function automatic exc_sel_t exc_select(
    input logic [3:0]      en,
    input logic            int_pend,
    input logic            sys,
    input logic            unimpl,
    input logic            ov,
    input logic            eret,
    input logic [XLEN-1:0] pc_f,
    input logic [XLEN-1:0] pc_d,
    input logic [XLEN-1:0] pc_e,
    input logic [XLEN-1:0] pc_m
  );
    exc_sel_t s;
    s = '0;
    if (ov && en[OV]) begin
      s.valid  = 1'b1;
      s.code   = OV;
      s.src_pc = pc_m;
    end else if (eret) begin
      s.valid  = 1'b1;
      s.is_ret = 1'b1;
    end else if (unimpl && en[UNIMPL]) begin
      s.valid  = 1'b1;
      s.code   = UNIMPL;
      s.src_pc = pc_e;
    end else if (sys && en[SYS]) begin
      s.valid  = 1'b1;
      s.code   = SYS;
      s.src_pc = pc_d;
    end else if (int_pend && en[INT]) begin
      s.valid  = 1'b1;
      s.code   = INT;
      s.src_pc = pc_f;
    end
    return s;
  endfunction

endpackage

// File: rtl/exc_int_pending.sv
// Interrupt input conditioning: register/synchronise, rising-edge detect, sticky pending bit.
// EXC_CTRL_INT_SYNC_EN selects a 2-flop synchroniser instead of a single register.
module exc_int_pending (
  input  logic clk,
  input  logic rst,
  input  logic int_req_i,
  input  logic clr_i,
  output logic pending_o
);

  logic int_s;
  logic int_prev_q;
  logic rise;

`ifdef EXC_CTRL_INT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], int_req_i};
  end

  assign int_s = sync_q[1];
`else
  logic req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= int_req_i;
  end

  assign int_s = req_q;
`endif

  assign rise = int_s & ~int_prev_q;

  // A new edge in the same cycle as an acceptance keeps the request alive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_prev_q <= 1'b0;
      pending_o  <= 1'b0;
    end else begin
      int_prev_q <= int_s;
      pending_o  <= (pending_o & ~clr_i) | rise;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt sequencer: prioritises events, issues entry/return strobes, flush and redirect.
// Build macro: EXC_CTRL_INT_SYNC_EN (2-flop synchroniser on int_req_i).
module exc_ctrl
  import exc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            int_req_i,
  input  logic            sys_d_i,
  input  logic            unimpl_e_i,
  input  logic            ov_m_i,
  input  logic            eret_m_i,
  input  logic [XLEN-1:0] pc_f_i,
  input  logic [XLEN-1:0] pc_d_i,
  input  logic [XLEN-1:0] pc_e_i,
  input  logic [XLEN-1:0] pc_m_i,
  input  logic [XLEN-1:0] status_i,
  input  logic [XLEN-1:0] epc_i,
  output logic            stall_o,
  output logic            cause_epc_write_o,
  output logic            ret_op_o,
  output logic [XLEN-1:0] exc_code_o,
  output logic [XLEN-1:0] epc_o,
  output logic [3:0]      flush_o,
  output logic            pc_redirect_o,
  output logic [XLEN-1:0] pc_target_o
);

  exc_state_e        state_q;
  logic [QCNT_W-1:0] qcnt_q;
  logic              int_pend;
  logic              int_clr;
  logic              idle;
  exc_sel_t          sel;
  logic [XLEN-5:0]   unused_status;

  assign unused_status = status_i[XLEN-1:4];

  exc_int_pending u_int_pending (
    .clk       (clk),
    .rst       (rst),
    .int_req_i (int_req_i),
    .clr_i     (int_clr),
    .pending_o (int_pend)
  );

  always_comb begin
    sel = exc_select(status_i[3:0], int_pend, sys_d_i, unimpl_e_i, ov_m_i, eret_m_i,
                     pc_f_i, pc_d_i, pc_e_i, pc_m_i);
  end

  assign idle    = (state_q == ST_IDLE);
  assign stall_o = idle & sel.valid;
  assign int_clr = stall_o & ~sel.is_ret & (sel.code == INT);

  // Sequencer with one-cycle registered strobes; all strobes drop back to 0 by default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      qcnt_q            <= '0;
      cause_epc_write_o <= 1'b0;
      ret_op_o          <= 1'b0;
      exc_code_o        <= '0;
      epc_o             <= '0;
      flush_o           <= '0;
      pc_redirect_o     <= 1'b0;
    end else begin
      cause_epc_write_o <= 1'b0;
      ret_op_o          <= 1'b0;
      exc_code_o        <= '0;
      epc_o             <= '0;
      flush_o           <= '0;
      pc_redirect_o     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sel.valid) begin
            pc_redirect_o <= 1'b1;
            if (sel.is_ret) begin
              state_q  <= ST_RET;
              ret_op_o <= 1'b1;
              flush_o  <= FLUSH_RET;
            end else begin
              state_q           <= ST_ENTER;
              cause_epc_write_o <= 1'b1;
              exc_code_o        <= {30'b0, sel.code};
              epc_o             <= sel.src_pc + 32'd4;
              flush_o           <= FLUSH_ALL;
            end
          end
        end
        ST_ENTER, ST_RET: begin
          state_q <= ST_QUIET;
          qcnt_q  <= QCNT_W'(QUIET_CYCLES - 1);
        end
        ST_QUIET: begin
          if (qcnt_q == '0) state_q <= ST_IDLE;
          else              qcnt_q  <= qcnt_q - QCNT_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The eret target must be the EPC visible in the RET cycle itself, so the target is a state decode.
  always_comb begin
    pc_target_o = '0;
    case (state_q)
      ST_ENTER: pc_target_o = HANDLER_ADDR;
      ST_RET:   pc_target_o = epc_i;
      default:  pc_target_o = '0;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus random traffic against a cycle-level event model.
module tb_exc_ctrl;
  import exc_pkg::*;

`ifdef EXC_CTRL_INT_SYNC_EN
  localparam int INT_DLY = 3;
`else
  localparam int INT_DLY = 2;
`endif
  localparam int Q = QUIET_CYCLES;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req_i, sys_d_i, unimpl_e_i, ov_m_i, eret_m_i;
  logic [31:0] pc_f_i, pc_d_i, pc_e_i, pc_m_i, status_i, epc_i;
  logic        stall_o, cause_epc_write_o, ret_op_o, pc_redirect_o;
  logic [31:0] exc_code_o, epc_o, pc_target_o;
  logic [3:0]  flush_o;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .int_req_i(int_req_i), .sys_d_i(sys_d_i),
    .unimpl_e_i(unimpl_e_i), .ov_m_i(ov_m_i), .eret_m_i(eret_m_i),
    .pc_f_i(pc_f_i), .pc_d_i(pc_d_i), .pc_e_i(pc_e_i), .pc_m_i(pc_m_i),
    .status_i(status_i), .epc_i(epc_i), .stall_o(stall_o),
    .cause_epc_write_o(cause_epc_write_o), .ret_op_o(ret_op_o),
    .exc_code_o(exc_code_o), .epc_o(epc_o), .flush_o(flush_o),
    .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history of the interrupt line, pending flag, busy countdown, next-cycle strobes.
  bit          hist[$];
  bit          m_pend, m_clr;
  int          m_busy;
  bit          e_enter, e_ret;
  logic [31:0] e_code, e_epc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < INT_DLY + 2; i++) hist.push_back(1'b0);
    m_pend = 0; m_clr = 0; m_busy = 0;
    e_enter = 0; e_ret = 0; e_code = 0; e_epc = 0;
  endtask

  task automatic clear_events();
    sys_d_i = 0; unimpl_e_i = 0; ov_m_i = 0; eret_m_i = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cew"},   32'(cause_epc_write_o), 32'd0);
    chk({tag, "_ret"},   32'(ret_op_o), 32'd0);
    chk({tag, "_code"},  exc_code_o, 32'd0);
    chk({tag, "_epc"},   epc_o, 32'd0);
    chk({tag, "_flush"}, 32'(flush_o), 32'd0);
    chk({tag, "_redir"}, 32'(pc_redirect_o), 32'd0);
    chk({tag, "_tgt"},   pc_target_o, 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  // One clock cycle: compare DUT to model at the falling edge, then advance the model.
  task automatic step();
    bit ov, er, un, sy, in, idle, any;
    @(negedge clk);
    hist.push_front(int_req_i);
    if (m_clr) m_pend = 0;
    m_clr = 0;
    if (hist[INT_DLY] && !hist[INT_DLY + 1]) m_pend = 1;
    void'(hist.pop_back());

    chk("cew",   32'(cause_epc_write_o), 32'(e_enter));
    chk("retop", 32'(ret_op_o), 32'(e_ret));
    chk("code",  exc_code_o, e_enter ? e_code : 32'd0);
    chk("epc",   epc_o, e_enter ? e_epc : 32'd0);
    chk("flush", 32'(flush_o), e_enter ? 32'hF : (e_ret ? 32'h7 : 32'h0));
    chk("redir", 32'(pc_redirect_o), 32'(e_enter | e_ret));
    chk("tgt",   pc_target_o, e_enter ? 32'h100 : (e_ret ? epc_i : 32'h0));

    idle = (m_busy == 0);
    ov = ov_m_i && status_i[3];
    er = eret_m_i;
    un = unimpl_e_i && status_i[2];
    sy = sys_d_i && status_i[1];
    in = m_pend && status_i[0];
    any = ov | er | un | sy | in;
    chk("stall", 32'(stall_o), 32'(idle && any));

    e_enter = 0; e_ret = 0;
    if (idle && any) begin
      m_busy = 1 + Q;
      if (ov)      begin e_enter = 1; e_code = 3; e_epc = pc_m_i + 32'd4; end
      else if (er) begin e_ret = 1; end
      else if (un) begin e_enter = 1; e_code = 2; e_epc = pc_e_i + 32'd4; end
      else if (sy) begin e_enter = 1; e_code = 1; e_epc = pc_d_i + 32'd4; end
      else         begin e_enter = 1; e_code = 0; e_epc = pc_f_i + 32'd4; m_clr = 1; end
    end else if (m_busy > 0) begin
      m_busy--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; int_req_i = 0; clear_events();
    pc_f_i = 32'h1000; pc_d_i = 32'h0FFC; pc_e_i = 32'h0FF8; pc_m_i = 32'h0FF4;
    status_i = 32'h0F; epc_i = 32'h0;
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    steps(3);

    // Overflow entry
    ov_m_i = 1; pc_m_i = 32'h40;
    step();
    clear_events();
    chk("ov_cew", 32'(cause_epc_write_o), 32'd1);
    chk("ov_code", exc_code_o, 32'd3);
    chk("ov_epc", epc_o, 32'h44);
    chk("ov_flush", 32'(flush_o), 32'hF);
    chk("ov_tgt", pc_target_o, 32'h100);
    steps(Q + 2);

    // UNIMPL beats SYS; SYS is dropped
    sys_d_i = 1; unimpl_e_i = 1; pc_e_i = 32'h20; pc_d_i = 32'h24;
    step();
    clear_events();
    chk("un_code", exc_code_o, 32'd2);
    chk("un_epc", epc_o, 32'h24);
    steps(Q + 4);

    // Masked interrupt stays pending, then accepted when enabled
    status_i = 32'h0E; int_req_i = 1;
    step();
    int_req_i = 0;
    steps(6);
    status_i = 32'h0F; pc_f_i = 32'h80;
    step();
    chk("int_code", exc_code_o, 32'd0);
    chk("int_epc", epc_o, 32'h84);
    chk("int_cew", 32'(cause_epc_write_o), 32'd1);
    steps(Q + 6);

    // eret; syscall during the quiet window is ignored
    eret_m_i = 1; epc_i = 32'h200;
    step();
    clear_events(); sys_d_i = 1;
    chk("eret_ret", 32'(ret_op_o), 32'd1);
    chk("eret_tgt", pc_target_o, 32'h200);
    chk("eret_flush", 32'(flush_o), 32'h7);
    chk("eret_cew", 32'(cause_epc_write_o), 32'd0);
    steps(Q + 1);
    sys_d_i = 0;
    steps(3);

    // Overflow and eret together: entry only
    ov_m_i = 1; eret_m_i = 1; pc_m_i = 32'h300;
    step();
    clear_events();
    chk("ovret_ret", 32'(ret_op_o), 32'd0);
    chk("ovret_cew", 32'(cause_epc_write_o), 32'd1);
    steps(Q + 2);

    // Reset during ENTER aborts
    sys_d_i = 1; pc_d_i = 32'h500;
    step();
    clear_events();
    chk("rst_pre_cew", 32'(cause_epc_write_o), 32'd1);
    rst = 1;
    #1;
    chk_all_zero("rst_enter");
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    steps(Q + 4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      ov_m_i     = ($urandom_range(0, 9) == 0);
      eret_m_i   = ($urandom_range(0, 11) == 0);
      unimpl_e_i = ($urandom_range(0, 9) == 0);
      sys_d_i    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) int_req_i = ~int_req_i;
      status_i = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'h0F;
      pc_f_i = $urandom & 32'hFFFF_FFFC;
      pc_d_i = $urandom & 32'hFFFF_FFFC;
      pc_e_i = $urandom & 32'hFFFF_FFFC;
      pc_m_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      epc_i  = $urandom;
      step();
    end
    clear_events(); int_req_i = 0;
    steps(Q + 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the pipelined CPU's coprocessor-0 register file. Each cycle it prioritises the external interrupt, syscall (ID), unimplemented-instruction (EX), overflow (MEM) and eret (MEM) events. It drives the CP0 write strobes, cause code and EPC value, flushes the pipeline, and redirects fetch to the handler or back to EPC. A small state machine enforces one event per entry plus a quiet window afterwards.

## Interface
- HANDLER_ADDR, 32'h0000_0100, fetch target on exception entry
- QUIET_CYCLES, 2, cycles after ENTER/RET during which new synchronous events are ignored (≥1)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- int_req_i  in  1  external interrupt request, asynchronous level
- sys_d_i / unimpl_e_i / ov_m_i  in  1 each  syscall in ID / unimplemented op in EX / overflow in MEM
- eret_m_i  in  1  eret in MEM
- pc_f_i, pc_d_i, pc_e_i, pc_m_i  in  32 each  PC of the instruction in each stage
- status_i  in  32  CP0 Status; bits [3:0] = enable mask indexed by ExcCode
- epc_i  in  32  CP0 EPC (eret target)
- stall_o  out  1  combinational freeze of F–M while an event is being captured
- cause_epc_write_o  out  1  CP0 exception-entry strobe
- ret_op_o  out  1  CP0 Status restore strobe
- exc_code_o  out  32  {30'b0, code}
- epc_o  out  32  value for CP0 EPC_i (stage PC + 4; CP0 subtracts 4)
- flush_o  out  4  {M,E,D,F} flush
- pc_redirect_o  out  1  take pc_target_o at fetch
- pc_target_o  out  32  redirect address

## Operation
- Codes: INT=0, SYS=1, UNIMPL=2, OV=3. An event is enabled only if status_i[code]=1. Disabled SYS/UNIMPL/OV are dropped and the instruction proceeds.
- Priority (oldest first): OV(M) > ERET(M) > UNIMPL(E) > SYS(D) > INT.
- EPC source: OV→pc_m_i, UNIMPL→pc_e_i, SYS→pc_d_i, INT→pc_f_i. epc_o = source + 4, 32-bit wrap.
- Interrupt pending bit: set on the rising edge of the internal interrupt signal. Cleared only when INT is accepted. Holds while masked or while a higher-priority event wins.
- States: IDLE, ENTER, RET, QUIET.
- IDLE: if any enabled event exists, stall_o=1 this cycle and code/epc are latched.
  - ERET → RET.
  - Any other event → ENTER.
- ENTER, one cycle:
  - cause_epc_write_o=1, exc_code_o=latched code, epc_o=latched value
  - flush_o=4'b1111, pc_redirect_o=1, pc_target_o=HANDLER_ADDR
  - → QUIET
- RET, one cycle:
  - ret_op_o=1, pc_redirect_o=1, pc_target_o=epc_i sampled in the RET cycle
  - flush_o=4'b0111 (eret itself retires)
  - → QUIET
- QUIET: counter loads QUIET_CYCLES-1 and decrements. Returns to IDLE after QUIET_CYCLES cycles. Synchronous events are ignored; interrupt pending still accumulates.
- status_i is sampled in IDLE only.

## Timing
- Reset: state=IDLE, pending=0, synchroniser=0, every output 0. A reset during ENTER/RET/QUIET aborts immediately; no strobe is issued after release.
- Event present in IDLE at cycle t: stall_o high in t. The strobe, flush and redirect are all registered and high for exactly one cycle, t+1.
- ENTER/RET strobes are never asserted together. At most one strobe per event.
- Back-to-back: the earliest next acceptance is cycle t+2+QUIET_CYCLES.
- Pending interrupt accepted the first IDLE cycle where status_i[0]=1 and no higher event is present.

## Configuration
- EXC_CTRL_INT_SYNC_EN defined: int_req_i passes a 2-flop synchroniser before edge detection. Pending sets 3 cycles after the input rises.
- Undefined: int_req_i is registered once, for an on-chip synchronous source. Pending sets 2 cycles after the input rises.

## Structure
- Package exc_pkg: ExcCode constants INT/SYS/UNIMPL/OV (2-bit), state enum, flush-mask constants FLUSH_ALL=4'b1111, FLUSH_RET=4'b0111.
- Sub-module exc_int_pending: synchroniser (macro-gated), rising-edge detect, and pending latch with clear input.

## Test plan
- status_i=0x0F, ov_m_i=1, pc_m_i=0x0000_0040 → t+1: cause_epc_write_o=1, exc_code_o=3, epc_o=0x44, flush_o=1111, pc_target_o=0x100.
- sys_d_i and unimpl_e_i together, pc_e_i=0x20 → code 2, epc_o=0x24; SYS dropped, no second strobe.
- int_req_i pulse while status_i=0x0E → no entry. Later status_i=0x0F → INT accepted, epc_o=pc_f_i+4, pending cleared.
- eret_m_i=1, epc_i=0x0000_0200 → t+1: ret_op_o=1, pc_target_o=0x200, flush_o=0111; a sys_d_i during QUIET is ignored.
- ov_m_i and eret_m_i together → exception entry only, ret_op_o stays 0.
- rst asserted in the ENTER cycle → all outputs 0 immediately; IDLE after release, no strobe.
